watch_mode_ctrl: RTL
====================

# watch_mode_ctrl

Mode controller for the watch. It owns the time-of-day, alarm and stopwatch registers and interprets the four debounced button pulses according to the 2-bit mode switch. It drives the four BCD digits (`thousands`/`hundreds`/`tens`/`ones`) and the blink mask consumed by the 7-segment scan driver. It sits between the button debouncers/1 Hz prescaler and the display multiplexer in `top`.

## Interface
- `ALARM_SECS`, default 30: number of `tick_1hz` pulses `alarm_active` stays high after triggering.
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick_1hz` in 1: single-cycle enable, once per second.
- `btnL`, `btnU`, `btnC`, `btnR` in 1 each: debounced single-cycle press pulses.
- `switch` in 2: mode select. 00 CLOCK, 01 SET_TIME, 10 STOPWATCH, 11 SET_ALARM.
- `thousands`, `hundreds`, `tens`, `ones` out 4 each: BCD digits, left to right.
- `blink` out 2: 10 = left pair blinking, 01 = right pair blinking, 00 = none.
- `alarm_en` out 1: alarm armed.
- `alarm_active` out 1: alarm ringing.

## Operation
**State**
- Time: BCD HH (00-23), MM, SS (00-59).
- Alarm: HH:MM.
- Stopwatch: MM:SS plus a run flag.
- Edit field `fsel` (0 = hours/left, 1 = minutes/right).
- Registered mode `mode_q` <= `switch` each cycle.
- On any `mode_q` change into 01 or 11: `fsel` <= 0.

**Button decode**
- At most one action per cycle. Priority U > C > L > R; lower-priority simultaneous pulses are dropped.
- If `alarm_active` = 1, any button pulse clears `alarm_active` and is consumed (no other action).

**Per mode**
- CLOCK: R toggles `alarm_en`; U/C/L ignored. Display HH:MM, `blink` = 00.
- SET_TIME:
  - Time is frozen; `tick_1hz` is ignored. SS <= 00 on entry.
  - L/R select `fsel` 0/1.
  - U increments the selected field, C decrements it.
  - Hours wrap 23<->00 and minutes wrap 59<->00, with no carry between fields.
  - Display HH:MM; `blink` = 10 (`fsel` = 0) or 01 (`fsel` = 1).
- STOPWATCH:
  - C toggles run.
  - U clears to 00:00 only when stopped; ignored while running.
  - Display MM:SS; `blink` = 00.
- SET_ALARM: same edit rules as SET_TIME, applied to alarm HH:MM; time keeps counting. Display alarm HH:MM; `blink` per `fsel`.

**Counting (all modes except time frozen in SET_TIME)**
- Time on `tick_1hz`: SS+1. 59 -> 00 carries into MM; MM 59 -> 00 carries into HH; 23:59:59 -> 00:00:00 in one cycle.
- Stopwatch on `tick_1hz` while running, in any mode: 59:59 saturates and clears run.

**Alarm**
- Triggers when a tick makes time == alarm HH:MM:00 and `alarm_en` = 1: `alarm_active` <= 1 and a counter loads `ALARM_SECS`.
- Counter decrements per tick; `alarm_active` clears when it reaches 0.
- Clearing `alarm_en` also clears `alarm_active`.
- A trigger while already active reloads the counter.

## Timing
- Reset (async, `rst_n` = 0):
  - Time 00:00:00, alarm 00:00, stopwatch 00:00 stopped, `fsel` = 0, `mode_q` = 00.
  - All digits 0, `blink` = 00, `alarm_en` = 0, `alarm_active` = 0.
  - Reset mid-edit or mid-alarm discards everything.
- Button/tick effect lands in state at the edge of the pulse cycle. Digit and blink outputs are registered from next state: they update 1 cycle after the pulse.
- Switch change: `mode_q` is 1 cycle late, so the display changes 2 cycles after `switch`. Buttons in the switch-change cycle use the old `mode_q`.
- A tick and a button in the same cycle in SET_ALARM or STOPWATCH are both applied. In STOPWATCH, a C-stop in the same cycle as a tick suppresses that tick's increment.

## Test plan
1. Reset, then 3 ticks in CLOCK -> time 00:00:03. Digits stay 0,0,0,0 (HH:MM). Switch to 10 with no run -> 0,0,0,0.
2. SET_TIME: U x23 -> hours 23. R, then C once -> minutes 59, `blink` = 01. Switch to 00, then 1 tick -> display 2,3,5,9. Tick 60 more -> 0,0,0,0 (midnight wrap).
3. STOPWATCH: C, 5 ticks, C -> display 0,0,0,5. Press U while running -> no clear. U after stop -> 0,0,0,0.
4. Alarm at 00:01 with `alarm_en` set: 60 ticks from 00:00:00 -> `alarm_active` = 1 on the 60th-tick edge. After `ALARM_SECS` more ticks -> 0. Repeat and press btnL -> cleared, no other effect.
5. U and C in the same cycle in SET_TIME (hours 05) -> hours 06 only.
6. Assert `rst_n` low mid-edit with the stopwatch running -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: owns time-of-day, alarm and stopwatch registers, decodes
// button pulses by mode and drives the registered BCD digits and blink mask.
module watch_mode_ctrl #(
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btnL,
    input  logic       btnU,
    input  logic       btnC,
    input  logic       btnR,
    input  logic [1:0] switch,
    output logic [3:0] thousands,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] blink,
    output logic       alarm_en,
    output logic       alarm_active
);
    localparam int CW = $clog2(ALARM_SECS + 1);

    typedef enum logic [1:0] {
        CLOCK     = 2'b00,
        SET_TIME  = 2'b01,
        STOPWATCH = 2'b10,
        SET_ALARM = 2'b11
    } mode_t;

    mode_t   mode_q, mode_d;
    logic [7:0] hh, mm, ss, hh_d, mm_d, ss_d;
    logic [7:0] al_hh, al_mm, al_hh_d, al_mm_d;
    logic [7:0] sw_mm, sw_ss, sw_mm_d, sw_ss_d;
    logic       sw_run, sw_run_d;
    logic       fsel, fsel_d;
    logic       alarm_en_d, alarm_active_d;
    logic [CW-1:0] alarm_cnt, alarm_cnt_d;
    logic [15:0] disp_d;
    logic [1:0]  blink_d;

    logic btn_any, take, do_u, do_c, do_l, do_r;
    logic time_run, time_hit, entering, sw_stop_c;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    // One winning action per cycle; a ringing alarm swallows every press.
    assign btn_any = btnU | btnC | btnL | btnR;
    assign take    = btn_any & ~alarm_active;
    assign do_u    = take & btnU;
    assign do_c    = take & btnC & ~btnU;
    assign do_l    = take & btnL & ~btnU & ~btnC;
    assign do_r    = take & btnR & ~btnU & ~btnC & ~btnL;

    assign time_run  = tick_1hz && (mode_q != SET_TIME);
    assign entering  = (switch != mode_q) && switch[0];
    assign sw_stop_c = (mode_q == STOPWATCH) && do_c && sw_run;

    always_comb begin
        mode_d         = mode_t'(switch);
        hh_d           = hh;
        mm_d           = mm;
        ss_d           = ss;
        al_hh_d        = al_hh;
        al_mm_d        = al_mm;
        sw_mm_d        = sw_mm;
        sw_ss_d        = sw_ss;
        sw_run_d       = sw_run;
        fsel_d         = fsel;
        alarm_en_d     = alarm_en;
        alarm_active_d = alarm_active;
        alarm_cnt_d    = alarm_cnt;
        time_hit       = 1'b0;

        if (time_run) begin
            ss_d = bcd_inc(ss, 8'h59);
            if (ss == 8'h59) begin
                mm_d = bcd_inc(mm, 8'h59);
                if (mm == 8'h59) hh_d = bcd_inc(hh, 8'h23);
            end
            time_hit = alarm_en && (hh_d == al_hh) && (mm_d == al_mm) && (ss_d == 8'h00);
        end

        // A stop press in the same cycle as a tick wins over that tick.
        if (tick_1hz && sw_run && !sw_stop_c) begin
            if ({sw_mm, sw_ss} == 16'h5959) begin
                sw_run_d = 1'b0;
            end else begin
                sw_ss_d = bcd_inc(sw_ss, 8'h59);
                if (sw_ss == 8'h59) sw_mm_d = bcd_inc(sw_mm, 8'h59);
            end
        end

        if (tick_1hz && alarm_active) begin
            alarm_cnt_d = alarm_cnt - CW'(1);
            if (alarm_cnt_d == '0) alarm_active_d = 1'b0;
        end
        if (alarm_active && btn_any) alarm_active_d = 1'b0;

        case (mode_q)
            CLOCK: begin
                if (do_r) begin
                    alarm_en_d = ~alarm_en;
                    if (alarm_en) alarm_active_d = 1'b0;
                end
            end
            SET_TIME: begin
                if (do_l) fsel_d = 1'b0;
                if (do_r) fsel_d = 1'b1;
                if (do_u) begin
                    if (fsel) mm_d = bcd_inc(mm, 8'h59);
                    else      hh_d = bcd_inc(hh, 8'h23);
                end
                if (do_c) begin
                    if (fsel) mm_d = bcd_dec(mm, 8'h59);
                    else      hh_d = bcd_dec(hh, 8'h23);
                end
            end
            STOPWATCH: begin
                if (do_c) sw_run_d = ~sw_run;
                if (do_u && !sw_run) begin
                    sw_mm_d = 8'h00;
                    sw_ss_d = 8'h00;
                end
            end
            SET_ALARM: begin
                if (do_l) fsel_d = 1'b0;
                if (do_r) fsel_d = 1'b1;
                if (do_u) begin
                    if (fsel) al_mm_d = bcd_inc(al_mm, 8'h59);
                    else      al_hh_d = bcd_inc(al_hh, 8'h23);
                end
                if (do_c) begin
                    if (fsel) al_mm_d = bcd_dec(al_mm, 8'h59);
                    else      al_hh_d = bcd_dec(al_hh, 8'h23);
                end
            end
            default: ;
        endcase

        if (time_hit) begin
            alarm_active_d = 1'b1;
            alarm_cnt_d    = CW'(ALARM_SECS);
        end

        if (entering) begin
            fsel_d = 1'b0;
            if (switch == SET_TIME) ss_d = 8'h00;
        end

        // Display follows the registered mode, so a switch shows two cycles later.
        case (mode_q)
            STOPWATCH: disp_d = {sw_mm_d, sw_ss_d};
            SET_ALARM: disp_d = {al_hh_d, al_mm_d};
            default:   disp_d = {hh_d, mm_d};
        endcase
        blink_d = mode_q[0] ? (fsel_d ? 2'b01 : 2'b10) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= CLOCK;
            hh           <= 8'h00;
            mm           <= 8'h00;
            ss           <= 8'h00;
            al_hh        <= 8'h00;
            al_mm        <= 8'h00;
            sw_mm        <= 8'h00;
            sw_ss        <= 8'h00;
            sw_run       <= 1'b0;
            fsel         <= 1'b0;
            alarm_en     <= 1'b0;
            alarm_active <= 1'b0;
            alarm_cnt    <= '0;
            thousands    <= 4'd0;
            hundreds     <= 4'd0;
            tens         <= 4'd0;
            ones         <= 4'd0;
            blink        <= 2'b00;
        end else begin
            mode_q       <= mode_d;
            hh           <= hh_d;
            mm           <= mm_d;
            ss           <= ss_d;
            al_hh        <= al_hh_d;
            al_mm        <= al_mm_d;
            sw_mm        <= sw_mm_d;
            sw_ss        <= sw_ss_d;
            sw_run       <= sw_run_d;
            fsel         <= fsel_d;
            alarm_en     <= alarm_en_d;
            alarm_active <= alarm_active_d;
            alarm_cnt    <= alarm_cnt_d;
            thousands    <= disp_d[15:12];
            hundreds     <= disp_d[11:8];
            tens         <= disp_d[7:4];
            ones         <= disp_d[3:0];
            blink        <= blink_d;
        end
    end
endmodule
